test_sequence_ctrl: RTL and testbench

TEST_SEQUENCE_CTRL -- requirements
Module: test_sequence_ctrl

---
 rtl/test_seq_pkg.sv | 43 ++++
 rtl/test_sequence_ctrl_if.sv | 32 +++
 rtl/test_seq_counter.sv | 29 ++
 rtl/test_sequence_ctrl.sv | 145 ++++++++++++++
 tb/tb_test_sequence_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/test_seq_pkg.sv
// Shared types and default timing for the test sequencing controller.
// Holds the state encoding seen on o_state and the counter sizing helpers.
package test_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_SEND    = 3'd3,
        ST_RUN     = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_DONE    = 3'd6
    } seq_state_t;

    localparam int DEF_RESET_HOLD_CYCLES  = 10;
    localparam int DEF_START_DELAY_CYCLES = 50;
    localparam int DEF_CHK_DELAY_CYCLES   = 5;
    localparam int DEF_TIMEOUT_CYCLES     = 60000;
    localparam int DEF_DRAIN_CYCLES       = 20;
    localparam int DEF_FAIL_WIDTH         = 3;

    // Never let a counter collapse to zero bits when its limit is zero.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // A state lasting N cycles loads N-1; zero still yields one cycle.
    function automatic int delay_load(input int cycles);
        return (cycles > 0) ? cycles - 1 : 0;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/test_sequence_ctrl_if.sv
// Bundle of the controller's handshake and status signals, one per DUT instance.
// master drives the device-side inputs, slave is the controller's view.
interface test_sequence_ctrl_if
    import test_seq_pkg::*;
#(
    parameter int FAIL_WIDTH = DEF_FAIL_WIDTH
);
    logic                  chip_ready;
    logic                  done;
    logic [FAIL_WIDTH-1:0] fail;
    logic                  reset_n;
    logic                  start_send;
    logic                  start_chk;
    logic                  test_complete;
    logic                  test_pass;
    logic                  timeout;
    logic                  fail_pulse;
    logic [FAIL_WIDTH-1:0] fail_latched;
    logic [2:0]            state;

    modport master (
        output chip_ready, done, fail,
        input  reset_n, start_send, start_chk, test_complete, test_pass,
        input  timeout, fail_pulse, fail_latched, state
    );

    modport slave (
        input  chip_ready, done, fail,
        output reset_n, start_send, start_chk, test_complete, test_pass,
        output timeout, fail_pulse, fail_latched, state
    );
endinterface

// File: rtl/test_seq_counter.sv
// Loadable saturating down-counter with a zero flag; used for phase
// delays and for the watchdog.
module test_seq_counter
    import test_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/test_sequence_ctrl.sv
// Sequences device reset, sender/checker start, watchdog and final verdict
// for a hardware test run once the chip reports it is configured.
module test_sequence_ctrl
    import test_seq_pkg::*;
#(
    parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
    parameter int START_DELAY_CYCLES = DEF_START_DELAY_CYCLES,
    parameter int CHK_DELAY_CYCLES   = DEF_CHK_DELAY_CYCLES,
    parameter int TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES,
    parameter int DRAIN_CYCLES       = DEF_DRAIN_CYCLES,
    parameter int FAIL_WIDTH         = DEF_FAIL_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_chip_ready,
    input  logic                  i_done,
    input  logic [FAIL_WIDTH-1:0] i_fail,
    output logic                  o_reset_n,
    output logic                  o_start_send,
    output logic                  o_start_chk,
    output logic                  o_test_complete,
    output logic                  o_test_pass,
    output logic                  o_timeout,
    output logic                  o_fail_pulse,
    output logic [FAIL_WIDTH-1:0] o_fail_latched,
    output logic [2:0]            o_state
);
    localparam int PH_MAX = max4(RESET_HOLD_CYCLES, START_DELAY_CYCLES,
                                 CHK_DELAY_CYCLES, DRAIN_CYCLES);
    localparam int PH_W   = cnt_width(PH_MAX);
    localparam int WD_W   = cnt_width(TIMEOUT_CYCLES);

    localparam logic [PH_W-1:0] LD_HOLD  = PH_W'(delay_load(RESET_HOLD_CYCLES));
    localparam logic [PH_W-1:0] LD_START = PH_W'(delay_load(START_DELAY_CYCLES));
    localparam logic [PH_W-1:0] LD_CHK   = PH_W'(delay_load(CHK_DELAY_CYCLES));
    localparam logic [PH_W-1:0] LD_DRAIN = PH_W'(delay_load(DRAIN_CYCLES));
    localparam logic [WD_W-1:0] LD_WDOG  = WD_W'(delay_load(TIMEOUT_CYCLES));

    seq_state_t            r_state;
    seq_state_t            w_state_next;
    logic                  r_timeout;
    logic                  r_done_seen;
    logic                  r_fail_pulse;
    logic [FAIL_WIDTH-1:0] r_fail_latched;

    logic                  w_ph_load;
    logic [PH_W-1:0]       w_ph_load_val;
    logic                  w_ph_zero;
    logic                  w_wd_zero;
    logic                  w_counted;
    logic                  w_fail_window;
    logic                  w_abort;
    logic                  w_wd_fire;

    assign w_counted     = r_state inside {ST_HOLD, ST_RELEASE, ST_SEND, ST_RUN};
    assign w_fail_window = r_state inside {ST_RELEASE, ST_SEND, ST_RUN, ST_DRAIN};
    assign w_abort       = !i_chip_ready && (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_wd_fire     = w_counted && w_wd_zero;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Losing chip_ready outranks a simultaneous timeout or phase expiry.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (i_chip_ready) w_state_next = ST_HOLD;
            ST_HOLD:    if (w_ph_zero)    w_state_next = ST_RELEASE;
            ST_RELEASE: if (w_ph_zero)    w_state_next = ST_SEND;
            ST_SEND:    if (w_ph_zero)    w_state_next = ST_RUN;
            ST_RUN:     if (i_done)       w_state_next = ST_DRAIN;
            ST_DRAIN:   if (w_ph_zero)    w_state_next = ST_DONE;
            ST_DONE:    w_state_next = ST_DONE;
            default:    w_state_next = ST_IDLE;
        endcase
        if (w_wd_fire) w_state_next = ST_DRAIN;
        if (w_abort)   w_state_next = ST_IDLE;
    end

    // The phase counter is reloaded on every state change with the length of the new state.
    always_comb begin
        w_ph_load     = (w_state_next != r_state);
        w_ph_load_val = '0;
        case (w_state_next)
            ST_HOLD:    w_ph_load_val = LD_HOLD;
            ST_RELEASE: w_ph_load_val = LD_START;
            ST_SEND:    w_ph_load_val = LD_CHK;
            ST_DRAIN:   w_ph_load_val = LD_DRAIN;
            default:    w_ph_load_val = '0;
        endcase
    end

    test_seq_counter #(.WIDTH(PH_W)) u_phase_cnt (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_ph_load),
        .i_load_val (w_ph_load_val),
        .i_en       (1'b1),
        .o_zero     (w_ph_zero)
    );

    test_seq_counter #(.WIDTH(WD_W)) u_watchdog_cnt (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (r_state == ST_IDLE),
        .i_load_val (LD_WDOG),
        .i_en       (w_counted),
        .o_zero     (w_wd_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset || w_abort) begin
            r_timeout      <= 1'b0;
            r_done_seen    <= 1'b0;
            r_fail_pulse   <= 1'b0;
            r_fail_latched <= '0;
        end else begin
            if (w_wd_fire) r_timeout <= 1'b1;
            if ((r_state == ST_RUN) && i_done) r_done_seen <= 1'b1;
            if (w_fail_window) begin
                r_fail_latched <= r_fail_latched | i_fail;
                r_fail_pulse   <= (r_fail_latched == '0) && (i_fail != '0);
            end else begin
                r_fail_pulse   <= 1'b0;
            end
        end
    end

    assign o_state         = r_state;
    assign o_reset_n       = r_state inside {ST_RELEASE, ST_SEND, ST_RUN, ST_DRAIN, ST_DONE};
    assign o_start_send    = r_state inside {ST_SEND, ST_RUN, ST_DRAIN, ST_DONE};
    assign o_start_chk     = r_state inside {ST_RUN, ST_DRAIN, ST_DONE};
    assign o_test_complete = (r_state == ST_DONE);
    assign o_test_pass     = (r_state == ST_DONE) && r_done_seen && !r_timeout
                             && (r_fail_latched == '0);
    assign o_timeout       = r_timeout;
    assign o_fail_pulse    = r_fail_pulse;
    assign o_fail_latched  = r_fail_latched;

endmodule

// File: tb/tb_test_sequence_ctrl.sv
// Directed and randomized bench for test_sequence_ctrl; two instances share
// stimulus, one with the default watchdog and one with a short watchdog.
module tb_test_sequence_ctrl;
    localparam int H = 10, S = 50, C = 5, D = 20, T_A = 60000, T_B = 100;
    localparam int HE = (H > 0) ? H : 1;
    localparam int SE = (S > 0) ? S : 1;
    localparam int CE = (C > 0) ? C : 1;
    localparam int DE = (D > 0) ? D : 1;

    logic       clk = 1'b0;
    logic       rst, rdy, dn;
    logic [2:0] fl;
    always #5 clk = ~clk;

    test_sequence_ctrl_if #(.FAIL_WIDTH(3)) if_a ();
    test_sequence_ctrl_if #(.FAIL_WIDTH(3)) if_b ();

    assign if_a.chip_ready = rdy;
    assign if_a.done       = dn;
    assign if_a.fail       = fl;
    assign if_b.chip_ready = rdy;
    assign if_b.done       = dn;
    assign if_b.fail       = fl;

    test_sequence_ctrl #(
        .RESET_HOLD_CYCLES(H), .START_DELAY_CYCLES(S), .CHK_DELAY_CYCLES(C),
        .TIMEOUT_CYCLES(T_A), .DRAIN_CYCLES(D), .FAIL_WIDTH(3)
    ) dut_a (
        .i_clk(clk), .i_reset(rst), .i_chip_ready(if_a.chip_ready),
        .i_done(if_a.done), .i_fail(if_a.fail), .o_reset_n(if_a.reset_n),
        .o_start_send(if_a.start_send), .o_start_chk(if_a.start_chk),
        .o_test_complete(if_a.test_complete), .o_test_pass(if_a.test_pass),
        .o_timeout(if_a.timeout), .o_fail_pulse(if_a.fail_pulse),
        .o_fail_latched(if_a.fail_latched), .o_state(if_a.state)
    );

    test_sequence_ctrl #(
        .RESET_HOLD_CYCLES(H), .START_DELAY_CYCLES(S), .CHK_DELAY_CYCLES(C),
        .TIMEOUT_CYCLES(T_B), .DRAIN_CYCLES(D), .FAIL_WIDTH(3)
    ) dut_b (
        .i_clk(clk), .i_reset(rst), .i_chip_ready(if_b.chip_ready),
        .i_done(if_b.done), .i_fail(if_b.fail), .o_reset_n(if_b.reset_n),
        .o_start_send(if_b.start_send), .o_start_chk(if_b.start_chk),
        .o_test_complete(if_b.test_complete), .o_test_pass(if_b.test_pass),
        .o_timeout(if_b.timeout), .o_fail_pulse(if_b.fail_pulse),
        .o_fail_latched(if_b.fail_latched), .o_state(if_b.state)
    );

    logic [12:0] act_a, act_b;
    assign act_a = {if_a.state, if_a.reset_n, if_a.start_send, if_a.start_chk,
                    if_a.test_complete, if_a.test_pass, if_a.timeout,
                    if_a.fail_pulse, if_a.fail_latched};
    assign act_b = {if_b.state, if_b.reset_n, if_b.start_send, if_b.start_chk,
                    if_b.test_complete, if_b.test_pass, if_b.timeout,
                    if_b.fail_pulse, if_b.fail_latched};

    // Reference model: elapsed cycles since the sequence began, plus when draining began.
    typedef struct {
        bit         active;
        int         t;
        int         drain_t;
        bit         tmo;
        bit         done_seen;
        logic [2:0] fail;
        bit         pulse;
    } mdl_t;

    mdl_t ma, mb;
    int   n_pass = 0, n_total = 0, cyc = 0, seqc = 0;
    int   rise_rn_a, rise_ss_a, rise_sc_a, rise_cmp_a, rise_cmp_b, rise_tmo_b;
    int   pul_a, pul_b, drn_b;
    logic [2:0] prev_b;

    function automatic mdl_t m_idle();
        mdl_t m;
        m.active = 0; m.t = 0; m.drain_t = -1; m.tmo = 0;
        m.done_seen = 0; m.fail = 3'b0; m.pulse = 0;
        return m;
    endfunction

    function automatic int m_state(input mdl_t m);
        if (!m.active) return 0;
        if (m.drain_t >= 0) return (m.t < m.drain_t + DE) ? 5 : 6;
        if (m.t < HE) return 1;
        if (m.t < HE + SE) return 2;
        if (m.t < HE + SE + CE) return 3;
        return 4;
    endfunction

    function automatic mdl_t m_step(input mdl_t m, input int tl, input logic r,
                                    input logic rd, input logic d, input logic [2:0] f);
        mdl_t n;
        int   st;
        int   lim;
        n = m;
        st = m_state(m);
        lim = (tl > 0) ? tl : 1;
        n.pulse = 0;
        if (r) begin
            n = m_idle();
        end else if (!m.active) begin
            if (rd) begin
                n = m_idle();
                n.active = 1;
            end
        end else if (st != 6 && !rd) begin
            n = m_idle();
        end else begin
            if (st >= 2 && st <= 5) begin
                n.pulse = (m.fail == 3'b0) && (f != 3'b0);
                n.fail  = m.fail | f;
            end
            if (st >= 1 && st <= 4) begin
                if (m.t + 1 >= lim) begin
                    n.tmo = 1;
                    n.drain_t = m.t + 1;
                end
                if (st == 4 && d) begin
                    n.done_seen = 1;
                    n.drain_t = m.t + 1;
                end
            end
            n.t = m.t + 1;
        end
        return n;
    endfunction

    function automatic logic [12:0] m_out(input mdl_t m);
        int         st;
        logic [2:0] s3;
        bit         pass;
        st = m_state(m);
        s3 = 3'(st);
        pass = (st == 6) && m.done_seen && !m.tmo && (m.fail == 3'b0);
        return {s3, st >= 2, st >= 3, st >= 4, st == 6, pass, m.tmo, m.pulse, m.fail};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        ma = m_step(ma, T_A, rst, rdy, dn, fl);
        mb = m_step(mb, T_B, rst, rdy, dn, fl);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check($sformatf("cycle%0d_dut_a", cyc), 32'(act_a), 32'(m_out(ma)));
        check($sformatf("cycle%0d_dut_b", cyc), 32'(act_b), 32'(m_out(mb)));
    endtask

    task automatic record();
        if (rise_rn_a  < 0 && if_a.reset_n)       rise_rn_a  = seqc;
        if (rise_ss_a  < 0 && if_a.start_send)    rise_ss_a  = seqc;
        if (rise_sc_a  < 0 && if_a.start_chk)     rise_sc_a  = seqc;
        if (rise_cmp_a < 0 && if_a.test_complete) rise_cmp_a = seqc;
        if (rise_cmp_b < 0 && if_b.test_complete) rise_cmp_b = seqc;
        if (rise_tmo_b < 0 && if_b.timeout)       rise_tmo_b = seqc;
        if (if_a.fail_pulse) pul_a++;
        if (if_b.fail_pulse) pul_b++;
        if (if_b.state == 3'd5 && prev_b != 3'd5) drn_b++;
        prev_b = if_b.state;
    endtask

    task automatic start_seq();
        rst = 0; rdy = 1; dn = 0; fl = 3'b0;
        tick();
        seqc = 0;
        rise_rn_a = -1; rise_ss_a = -1; rise_sc_a = -1;
        rise_cmp_a = -1; rise_cmp_b = -1; rise_tmo_b = -1;
        pul_a = 0; pul_b = 0; drn_b = 0; prev_b = 3'd0;
        record();
    endtask

    task automatic step_seq(input int done_at, input int fail_at, input logic [2:0] fv,
                            input int drop_at, input int rst_at);
        rst = (seqc == rst_at);
        rdy = (seqc != drop_at);
        dn  = (done_at >= 0) && (seqc >= done_at);
        fl  = (seqc == fail_at) ? fv : 3'b0;
        tick();
        seqc++;
        record();
    endtask

    task automatic step_rand(input int done_at);
        rst = ($urandom_range(0, 399) == 0);
        rdy = ($urandom_range(0, 149) != 0);
        dn  = (seqc >= done_at);
        fl  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'b0;
        tick();
        seqc++;
        record();
    endtask

    task automatic reset_dut();
        rst = 1; rdy = 0; dn = 0; fl = 3'b0;
        tick();
        rst = 0;
        tick();
    endtask

    initial begin
        rst = 1; rdy = 0; dn = 0; fl = 3'b0;
        ma = m_idle(); mb = m_idle();
        tick();
        tick();
        check("reset_outputs_a", 32'(act_a), 32'd0);
        check("reset_outputs_b", 32'(act_b), 32'd0);
        rdy = 1;
        tick();
        check("reset_priority_state", 32'(if_a.state), 32'd0);
        rst = 0; rdy = 0;
        tick();

        // Nominal run; the short-watchdog instance times out on the same stimulus.
        start_seq();
        repeat (230) step_seq(200, -1, 3'b0, -1, -1);
        check("nom_reset_n_rise", rise_rn_a, 10);
        check("nom_start_send_rise", rise_ss_a, 60);
        check("nom_start_chk_rise", rise_sc_a, 65);
        check("nom_complete_rise", rise_cmp_a, 221);
        check("nom_pass", 32'(if_a.test_pass), 32'd1);
        check("tmo_flag_rise", rise_tmo_b, 100);
        check("tmo_complete_rise", rise_cmp_b, 120);
        check("tmo_pass", 32'(if_b.test_pass), 32'd0);

        // Single-cycle fail in RUN.
        reset_dut();
        start_seq();
        repeat (120) step_seq(90, 70, 3'b010, -1, -1);
        check("fail_pulse_count", pul_a, 1);
        check("fail_latched_held", 32'(if_a.fail_latched), 32'b010);
        check("fail_complete", 32'(if_a.test_complete), 32'd1);
        check("fail_pass", 32'(if_a.test_pass), 32'd0);

        // chip_ready dropped during SEND, then the sequence restarts.
        reset_dut();
        start_seq();
        repeat (63) step_seq(-1, -1, 3'b0, 62, -1);
        check("drop_state_idle", 32'(if_a.state), 32'd0);
        check("drop_start_send", 32'(if_a.start_send), 32'd0);
        check("drop_reset_n", 32'(if_a.reset_n), 32'd0);
        start_seq();
        repeat (120) step_seq(90, -1, 3'b0, -1, -1);
        check("rerun_reset_n_rise", rise_rn_a, 10);
        check("rerun_start_send_rise", rise_ss_a, 60);
        check("rerun_start_chk_rise", rise_sc_a, 65);
        check("rerun_complete_rise", rise_cmp_a, 111);
        check("rerun_pass", 32'(if_a.test_pass), 32'd1);

        // Reset pulse while draining with a latched fail.
        reset_dut();
        start_seq();
        repeat (85) step_seq(80, 70, 3'b010, -1, 85);
        check("drain_state_before_rst", 32'(if_a.state), 32'd5);
        check("drain_fail_before_rst", 32'(if_a.fail_latched), 32'b010);
        step_seq(80, 70, 3'b010, -1, 85);
        check("drain_rst_outputs", 32'(act_a), 32'd0);
        check("drain_rst_fail_cleared", 32'(if_a.fail_latched), 32'd0);

        // Done arrives in the very cycle the short watchdog expires.
        reset_dut();
        start_seq();
        repeat (130) step_seq(99, -1, 3'b0, -1, -1);
        check("both_timeout", 32'(if_b.timeout), 32'd1);
        check("both_pass", 32'(if_b.test_pass), 32'd0);
        check("both_complete_rise", rise_cmp_b, 120);
        check("both_drain_entries", drn_b, 1);
        check("both_ref_pass", 32'(if_a.test_pass), 32'd1);

        for (int r = 0; r < 6; r++) begin
            int done_at;
            reset_dut();
            start_seq();
            done_at = $urandom_range(70, 240);
            repeat (260) step_rand(done_at);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
